spi_flash_resp: RTL and testbench
=================================

SPI_FLASH_RESP -- requirements
Module: spi_flash_resp

Interface
REQ-001 Parameter SYNC_STAGES, default 2, flip-flop count of the input synchronizer on spi_sck/spi_ss/spi_mosi.
REQ-002 Parameter CMD_READ, default 8'h03, the only accepted command opcode.
REQ-003 clock  input  1  sole clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 spi_sck  input  1  SPI serial clock, mode 0 (idle low), asynchronous to clock.
REQ-006 spi_ss  input  1  chip select, active low.
REQ-007 spi_mosi  input  1  master-to-slave data, MSB first.
REQ-008 spi_miso  output  1  slave-to-master data, MSB first, registered.
REQ-009 mem_req  output  1  one-cycle pulse requesting a word read.
REQ-010 mem_addr  output  24  word-aligned byte address ({addr[23:2],2'b00}), held stable until the next mem_req.
REQ-011 mem_rdata  input  32  read word, little-endian (byte at mem_addr in bits [7:0]), valid exactly one cycle after mem_req.
REQ-012 busy  output  1  high while a transaction is active (state not IDLE).
REQ-013 cmd_err  output  1  one-cycle pulse when a non-CMD_READ opcode completes.

Function
REQ-014 Inputs SHALL pass through SYNC_STAGES flops; rising/falling SCK edges SHALL be detected from the synchronized value and its one-cycle delay.
REQ-015 Correct operation SHALL require the spi_sck half-period >= SYNC_STAGES+3 clock cycles; behaviour at a faster SCK is undefined.
REQ-016 States: IDLE, CMD, ADDR, FETCH, DATA, IGNORE.
REQ-017 IDLE -> CMD on synchronized spi_ss falling; the bit counter SHALL clear to 0.
REQ-018 CMD: sample mosi on each SCK rising edge; after 8 bits -> ADDR if opcode==CMD_READ, else pulse cmd_err and -> IGNORE.
REQ-019 ADDR: shift 24 bits MSB first; on the 24th rising edge -> FETCH.
REQ-020 FETCH: assert mem_req for one cycle at the entry cycle; capture mem_rdata the next cycle into the shift buffer; -> DATA.
REQ-021 DATA: on each SCK falling edge, drive spi_miso with the next bit; byte order starts at addr[1:0] within the word, bits MSB first per byte.
REQ-022 The first data bit SHALL be driven on the first SCK falling edge after the 24th address rising edge; FETCH completes before that edge, per REQ-015.
REQ-023 After the last bit of byte 3 of a word, the next word SHALL be fetched (address +4, 24-bit wrap 0xFFFFFC -> 0x000000) so that the burst continues with no gap, prefetch issued during bit 0 of the final byte.
REQ-024 Unaligned start: the first word SHALL supply only bytes addr[1:0]..3; subsequent words SHALL be fully sent.
REQ-025 IGNORE: spi_miso held 0, no mem_req, until spi_ss rises.
REQ-026 spi_ss rising in any state SHALL force IDLE the next cycle, discard partial bits, and drive spi_miso 0; any outstanding capture SHALL be dropped.
REQ-027 spi_ss rising and an SCK edge in the same cycle: the ss deassertion SHALL win.
REQ-028 spi_miso SHALL be 0 whenever not in DATA.

Reset
REQ-029 On reset: state IDLE, spi_miso 0, mem_req 0, mem_addr 0, busy 0, cmd_err 0, counters and shift registers 0, synchronizer flops loaded with sck=0, ss=1, mosi=0.
REQ-030 Reset asserted mid-transaction SHALL abort it; after reset release the block SHALL wait for a fresh spi_ss falling edge even if ss is already low.

Structure
REQ-031 Package spi_flash_pkg SHALL hold the state enum, CMD_READ default, and address/data width constants.
REQ-032 One sub-module spi_in_sync SHALL implement the synchronizer plus SCK rise/fall and SS fall/rise pulse generation.

Verification
REQ-033 Read 0x03, addr 0x000010, 32 SCK data cycles, memory word at 0x10 = 0xDDCCBBAA -> miso bytes AA,BB,CC,DD; one mem_req, mem_addr 0x000010.
REQ-034 Burst of 64 data bits from 0x000020 -> two mem_req (0x20, 0x24), no idle bit between words.
REQ-035 Unaligned addr 0x000013, word 0x44332211, next word 0x88776655 -> bytes 44,55,66.
REQ-036 Opcode 0x9F -> cmd_err pulse once, no mem_req, miso 0 until ss high.
REQ-037 ss raised after 12 address bits, then new read 0x03/0x000000 -> correct data from 0x000000 and no stale state.
REQ-038 Burst from 0xFFFFFC across the boundary -> second mem_addr 0x000000.

Source files
------------

// File: rtl/spi_flash_pkg.sv
// Shared types and constants for the SPI flash read responder.
// Holds the controller state encoding and bus width constants.
package spi_flash_pkg;

    localparam int ADDR_W = 24;
    localparam int DATA_W = 32;

    localparam logic [7:0] CMD_READ_DEF = 8'h03;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_ADDR,
        ST_FETCH,
        ST_DATA,
        ST_IGNORE
    } state_t;

endpackage

// File: rtl/spi_flash_resp_sync.sv
// Synchronizer for the asynchronous SPI pins plus edge pulse generation.
// SS falling edges are only reported once SS has been seen high after reset.
module spi_in_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clock,
    input  logic reset,
    input  logic spi_sck,
    input  logic spi_ss,
    input  logic spi_mosi,
    output logic sck_rise,
    output logic sck_fall,
    output logic ss_fall,
    output logic ss_rise,
    output logic mosi
);

    logic [SYNC_STAGES-1:0] sck_q;
    logic [SYNC_STAGES-1:0] ss_q;
    logic [SYNC_STAGES-1:0] mosi_q;
    logic                   sck_s;
    logic                   ss_s;
    logic                   sck_d;
    logic                   ss_d;
    logic                   armed;
    logic [7:0]             fill;

    assign sck_s = sck_q[SYNC_STAGES-1];
    assign ss_s  = ss_q[SYNC_STAGES-1];
    assign mosi  = mosi_q[SYNC_STAGES-1];

    always_ff @(posedge clock) begin
        if (reset) begin
            sck_q  <= '0;
            ss_q   <= '1;
            mosi_q <= '0;
            sck_d  <= 1'b0;
            ss_d   <= 1'b1;
            armed  <= 1'b0;
            fill   <= '0;
        end else begin
            sck_q  <= (sck_q << 1) | SYNC_STAGES'(spi_sck);
            ss_q   <= (ss_q << 1) | SYNC_STAGES'(spi_ss);
            mosi_q <= (mosi_q << 1) | SYNC_STAGES'(spi_mosi);
            sck_d  <= sck_s;
            ss_d   <= ss_s;
            // Chain holds reset values until it has been refilled from the pins
            if (fill != 8'(SYNC_STAGES)) begin
                fill <= fill + 8'd1;
            end else if (ss_s) begin
                armed <= 1'b1;
            end
        end
    end

    assign sck_rise = sck_s & ~sck_d;
    assign sck_fall = ~sck_s & sck_d;
    assign ss_fall  = armed & ss_d & ~ss_s;
    assign ss_rise  = ss_s & ~ss_d;

endmodule

// File: rtl/spi_flash_resp.sv
// SPI mode-0 flash read responder: accepts a read opcode and 24-bit address,
// then streams little-endian memory words MSB-first per byte with prefetch.
module spi_flash_resp
    import spi_flash_pkg::*;
#(
    parameter int         SYNC_STAGES = 2,
    parameter logic [7:0] CMD_READ    = CMD_READ_DEF
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              spi_sck,
    input  logic              spi_ss,
    input  logic              spi_mosi,
    output logic              spi_miso,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic              cmd_err
);

    logic sck_rise;
    logic sck_fall;
    logic ss_fall;
    logic ss_rise;
    logic mosi;

    spi_in_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clock   (clock),
        .reset   (reset),
        .spi_sck (spi_sck),
        .spi_ss  (spi_ss),
        .spi_mosi(spi_mosi),
        .sck_rise(sck_rise),
        .sck_fall(sck_fall),
        .ss_fall (ss_fall),
        .ss_rise (ss_rise),
        .mosi    (mosi)
    );

    state_t              state;
    logic [4:0]          bit_cnt;
    logic [6:0]          cmd_sr;
    logic [ADDR_W-2:0]   addr_sr;
    logic [DATA_W-1:0]   data_buf;
    logic [1:0]          byte_idx;
    logic [2:0]          bit_pos;
    logic                last_bit;
    logic                cap;
    logic [7:0]          opcode_next;
    logic [ADDR_W-1:0]   addr_next;
    logic                tx_bit;

    assign opcode_next = {cmd_sr, mosi};
    assign addr_next   = {addr_sr, mosi};
    assign tx_bit      = data_buf[{byte_idx, bit_pos}];

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= ST_IDLE;
            bit_cnt  <= '0;
            cmd_sr   <= '0;
            addr_sr  <= '0;
            data_buf <= '0;
            byte_idx <= '0;
            bit_pos  <= '0;
            last_bit <= 1'b0;
            cap      <= 1'b0;
            spi_miso <= 1'b0;
            mem_req  <= 1'b0;
            mem_addr <= '0;
            busy     <= 1'b0;
            cmd_err  <= 1'b0;
        end else begin
            mem_req <= 1'b0;
            cmd_err <= 1'b0;
            // Read data arrives the cycle after the request pulse
            cap     <= mem_req;
            if (ss_rise) begin
                state    <= ST_IDLE;
                busy     <= 1'b0;
                spi_miso <= 1'b0;
                mem_req  <= 1'b0;
                cap      <= 1'b0;
                bit_cnt  <= '0;
                last_bit <= 1'b0;
            end else begin
                unique case (state)
                    ST_IDLE: begin
                        if (ss_fall) begin
                            state   <= ST_CMD;
                            busy    <= 1'b1;
                            bit_cnt <= '0;
                            cmd_sr  <= '0;
                            addr_sr <= '0;
                        end
                    end
                    ST_CMD: begin
                        if (sck_rise) begin
                            cmd_sr  <= opcode_next[6:0];
                            bit_cnt <= bit_cnt + 5'd1;
                            if (bit_cnt == 5'd7) begin
                                bit_cnt <= '0;
                                if (opcode_next == CMD_READ) begin
                                    state <= ST_ADDR;
                                end else begin
                                    cmd_err <= 1'b1;
                                    state   <= ST_IGNORE;
                                end
                            end
                        end
                    end
                    ST_ADDR: begin
                        if (sck_rise) begin
                            addr_sr <= addr_next[ADDR_W-2:0];
                            bit_cnt <= bit_cnt + 5'd1;
                            if (bit_cnt == 5'd23) begin
                                bit_cnt  <= '0;
                                state    <= ST_FETCH;
                                mem_req  <= 1'b1;
                                mem_addr <= {addr_next[ADDR_W-1:2], 2'b00};
                                byte_idx <= addr_next[1:0];
                                bit_pos  <= 3'd7;
                            end
                        end
                    end
                    ST_FETCH: begin
                        if (cap) begin
                            data_buf <= mem_rdata;
                            state    <= ST_DATA;
                        end
                    end
                    ST_DATA: begin
                        if (cap) begin
                            data_buf <= mem_rdata;
                        end
                        if (sck_fall) begin
                            spi_miso <= tx_bit;
                            last_bit <= (byte_idx == 2'd3) && (bit_pos == 3'd0);
                            bit_pos  <= bit_pos - 3'd1;
                            if (bit_pos == 3'd0) begin
                                byte_idx <= byte_idx + 2'd1;
                            end
                        end else if (sck_rise && last_bit) begin
                            // Next word lands before the following falling edge
                            last_bit <= 1'b0;
                            mem_req  <= 1'b1;
                            mem_addr <= mem_addr + 24'd4;
                        end
                    end
                    ST_IGNORE: begin
                        spi_miso <= 1'b0;
                    end
                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_spi_flash_resp.sv
// Directed bench for spi_flash_resp: SPI master tasks, a one-cycle-latency
// memory model and per-scenario checks against hand-computed bytes.
module tb_spi_flash_resp;

    localparam int HALF = 80;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        spi_sck = 1'b0;
    logic        spi_ss = 1'b1;
    logic        spi_mosi = 1'b0;
    logic        spi_miso;
    logic        mem_req;
    logic [23:0] mem_addr;
    logic [31:0] mem_rdata = '0;
    logic        busy;
    logic        cmd_err;

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] mem [logic [23:0]];
    logic [23:0] req_q [$];
    int          err_cnt = 0;

    spi_flash_resp dut (
        .clock    (clock),
        .reset    (reset),
        .spi_sck  (spi_sck),
        .spi_ss   (spi_ss),
        .spi_mosi (spi_mosi),
        .spi_miso (spi_miso),
        .mem_req  (mem_req),
        .mem_addr (mem_addr),
        .mem_rdata(mem_rdata),
        .busy     (busy),
        .cmd_err  (cmd_err)
    );

    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (mem_req === 1'b1) begin
            mem_rdata <= mem.exists(mem_addr) ? mem[mem_addr] : 32'hDEADBEEF;
            req_q.push_back(mem_addr);
        end
        if (cmd_err === 1'b1) err_cnt = err_cnt + 1;
    end

    task automatic sck_bit(input logic o, output logic i);
        spi_mosi = o;
        #HALF;
        spi_sck = 1'b1;
        i = spi_miso;
        #HALF;
        spi_sck = 1'b0;
    endtask

    task automatic xfer(input logic [7:0] o, output logic [7:0] i);
        logic b;
        for (int k = 7; k >= 0; k--) begin
            sck_bit(o[k], b);
            i[k] = b;
        end
    endtask

    task automatic ss_down();
        spi_ss = 1'b0;
        #HALF;
    endtask

    task automatic ss_up();
        #HALF;
        spi_ss = 1'b1;
        #200;
    endtask

    task automatic start_read(input logic [23:0] a);
        logic [7:0] d;
        ss_down();
        xfer(8'h03, d);
        xfer(a[23:16], d);
        xfer(a[15:8], d);
        xfer(a[7:0], d);
    endtask

    task automatic test_reset();
        repeat (5) @(posedge clock);
        #2;
        reset = 1'b0;
        #20;
        n_cmp++; if (spi_miso !== 1'b0) begin n_bad++; $display("FAIL reset_miso: got %b want 0", spi_miso); end
        n_cmp++; if (mem_req !== 1'b0) begin n_bad++; $display("FAIL reset_req: got %b want 0", mem_req); end
        n_cmp++; if (mem_addr !== 24'h0) begin n_bad++; $display("FAIL reset_addr: got %h want 000000", mem_addr); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_cmp++; if (cmd_err !== 1'b0) begin n_bad++; $display("FAIL reset_err: got %b want 0", cmd_err); end
    endtask

    task automatic test_read();
        logic [7:0] d;
        logic [7:0] e;
        logic [31:0] w;
        logic b;
        mem.delete();
        mem[24'h000010] = 32'hDDCCBBAA;
        w = 32'hDDCCBBAA;
        req_q.delete();
        start_read(24'h000010);
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL read_busy: got %b want 1", busy); end
        for (int j = 0; j < 3; j++) begin
            xfer(8'h00, d);
            e = w[8*j +: 8];
            n_cmp++; if (d !== e) begin n_bad++; $display("FAIL read_byte%0d: got %h want %h", j, d, e); end
        end
        for (int k = 7; k >= 1; k--) begin
            sck_bit(1'b0, b);
            d[k] = b;
        end
        n_cmp++; if (req_q.size() !== 1) begin n_bad++; $display("FAIL read_reqs: got %0d want 1", req_q.size()); end
        sck_bit(1'b0, b);
        d[0] = b;
        n_cmp++; if (d !== 8'hDD) begin n_bad++; $display("FAIL read_byte3: got %h want dd", d); end
        e = 8'h00;
        n_cmp++; if ((req_q.size() > 0 ? req_q[0] : 24'hxxxxxx) !== 24'h000010) begin n_bad++; $display("FAIL read_addr: got %h want 000010", req_q.size() > 0 ? req_q[0] : 24'hxxxxxx); end
        ss_up();
        n_cmp++; if (spi_miso !== 1'b0) begin n_bad++; $display("FAIL read_miso_idle: got %b want 0", spi_miso); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL read_busy_idle: got %b want 0", busy); end
    endtask

    task automatic test_burst();
        logic [7:0] d;
        logic [7:0] e;
        mem.delete();
        mem[24'h000020] = 32'h13121110;
        mem[24'h000024] = 32'h17161514;
        req_q.delete();
        start_read(24'h000020);
        for (int j = 0; j < 8; j++) begin
            xfer(8'h00, d);
            e = 8'h10 + 8'(j);
            n_cmp++; if (d !== e) begin n_bad++; $display("FAIL burst_byte%0d: got %h want %h", j, d, e); end
        end
        n_cmp++; if ((req_q.size() > 0 ? req_q[0] : 24'hxxxxxx) !== 24'h000020) begin n_bad++; $display("FAIL burst_addr0: got %h want 000020", req_q.size() > 0 ? req_q[0] : 24'hxxxxxx); end
        n_cmp++; if ((req_q.size() > 1 ? req_q[1] : 24'hxxxxxx) !== 24'h000024) begin n_bad++; $display("FAIL burst_addr1: got %h want 000024", req_q.size() > 1 ? req_q[1] : 24'hxxxxxx); end
        ss_up();
    endtask

    task automatic test_unaligned();
        logic [7:0] d;
        logic [23:0] exp_b;
        mem.delete();
        mem[24'h000010] = 32'h44332211;
        mem[24'h000014] = 32'h88776655;
        exp_b = 24'h445566;
        req_q.delete();
        start_read(24'h000013);
        for (int j = 0; j < 3; j++) begin
            xfer(8'h00, d);
            n_cmp++; if (d !== exp_b[23-8*j -: 8]) begin n_bad++; $display("FAIL unal_byte%0d: got %h want %h", j, d, exp_b[23-8*j -: 8]); end
        end
        n_cmp++; if (req_q.size() !== 2) begin n_bad++; $display("FAIL unal_reqs: got %0d want 2", req_q.size()); end
        n_cmp++; if ((req_q.size() > 0 ? req_q[0] : 24'hxxxxxx) !== 24'h000010) begin n_bad++; $display("FAIL unal_addr0: got %h want 000010", req_q.size() > 0 ? req_q[0] : 24'hxxxxxx); end
        n_cmp++; if ((req_q.size() > 1 ? req_q[1] : 24'hxxxxxx) !== 24'h000014) begin n_bad++; $display("FAIL unal_addr1: got %h want 000014", req_q.size() > 1 ? req_q[1] : 24'hxxxxxx); end
        ss_up();
    endtask

    task automatic test_bad_cmd();
        logic [7:0] d;
        logic [7:0] acc;
        req_q.delete();
        err_cnt = 0;
        acc = 8'h00;
        ss_down();
        xfer(8'h9F, d);
        #50;
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL bad_busy: got %b want 1", busy); end
        for (int j = 0; j < 3; j++) begin
            xfer(8'hFF, d);
            acc = acc | d;
        end
        n_cmp++; if (acc !== 8'h00) begin n_bad++; $display("FAIL bad_miso: got %h want 00", acc); end
        ss_up();
        n_cmp++; if (err_cnt !== 1) begin n_bad++; $display("FAIL bad_errcnt: got %0d want 1", err_cnt); end
        n_cmp++; if (req_q.size() !== 0) begin n_bad++; $display("FAIL bad_reqs: got %0d want 0", req_q.size()); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL bad_busy_idle: got %b want 0", busy); end
    endtask

    task automatic test_abort();
        logic [7:0] d;
        logic b;
        req_q.delete();
        ss_down();
        xfer(8'h03, d);
        for (int k = 0; k < 12; k++) sck_bit(1'b1, b);
        ss_up();
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL abort_busy: got %b want 0", busy); end
        mem.delete();
        mem[24'h000000] = 32'h0D0C0B0A;
        start_read(24'h000000);
        xfer(8'h00, d);
        n_cmp++; if (d !== 8'h0A) begin n_bad++; $display("FAIL abort_byte0: got %h want 0a", d); end
        xfer(8'h00, d);
        n_cmp++; if (d !== 8'h0B) begin n_bad++; $display("FAIL abort_byte1: got %h want 0b", d); end
        n_cmp++; if (req_q.size() !== 1) begin n_bad++; $display("FAIL abort_reqs: got %0d want 1", req_q.size()); end
        n_cmp++; if ((req_q.size() > 0 ? req_q[0] : 24'hxxxxxx) !== 24'h000000) begin n_bad++; $display("FAIL abort_addr: got %h want 000000", req_q.size() > 0 ? req_q[0] : 24'hxxxxxx); end
        ss_up();
    endtask

    task automatic test_wrap();
        logic [7:0] d;
        logic [7:0] e;
        mem.delete();
        mem[24'hFFFFFC] = 32'hA3A2A1A0;
        mem[24'h000000] = 32'h0D0C0B0A;
        req_q.delete();
        start_read(24'hFFFFFC);
        for (int j = 0; j < 8; j++) begin
            xfer(8'h00, d);
            e = (j < 4) ? 8'hA0 + 8'(j) : 8'h0A + 8'(j - 4);
            n_cmp++; if (d !== e) begin n_bad++; $display("FAIL wrap_byte%0d: got %h want %h", j, d, e); end
        end
        n_cmp++; if ((req_q.size() > 0 ? req_q[0] : 24'hxxxxxx) !== 24'hFFFFFC) begin n_bad++; $display("FAIL wrap_addr0: got %h want fffffc", req_q.size() > 0 ? req_q[0] : 24'hxxxxxx); end
        n_cmp++; if ((req_q.size() > 1 ? req_q[1] : 24'hxxxxxx) !== 24'h000000) begin n_bad++; $display("FAIL wrap_addr1: got %h want 000000", req_q.size() > 1 ? req_q[1] : 24'hxxxxxx); end
        ss_up();
    endtask

    task automatic test_reset_mid();
        logic [7:0] d;
        mem.delete();
        mem[24'h000000] = 32'h0D0C0B0A;
        ss_down();
        xfer(8'h03, d);
        xfer(8'h00, d);
        reset = 1'b1;
        repeat (3) @(posedge clock);
        #2;
        reset = 1'b0;
        req_q.delete();
        #100;
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rmid_busy: got %b want 0", busy); end
        xfer(8'h03, d);
        xfer(8'h00, d);
        xfer(8'h00, d);
        xfer(8'h00, d);
        xfer(8'h00, d);
        n_cmp++; if (d !== 8'h00) begin n_bad++; $display("FAIL rmid_miso: got %h want 00", d); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rmid_busy2: got %b want 0", busy); end
        n_cmp++; if (req_q.size() !== 0) begin n_bad++; $display("FAIL rmid_reqs: got %0d want 0", req_q.size()); end
        ss_up();
    endtask

    initial begin
        test_reset();
        test_read();
        test_burst();
        test_unaligned();
        test_bad_cmd();
        test_abort();
        test_wrap();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
